// File: rtl/voice_display_scheduler.sv
// voice_display_scheduler: validate received voice-command bytes, queue them and pace them onto the 7-segment display
module voice_display_scheduler #(
    parameter int          DEPTH       = 4,
    parameter logic [26:0] HOLD_CYCLES = 27'd100_000_000,
    parameter logic [27:0] IDLE_CYCLES = 28'd200_000_000,
    parameter int          CNT_W       = 28,
    parameter logic [5:0]  MAX_ID      = 6'd35,
    parameter logic [5:0]  BLANK_ID    = 6'd63
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic [7:0] rx_data,
    input  logic       rx_busy,
    output logic [5:0] id_out,
    output logic       id_valid,
    output logic       fifo_full,
    output logic       overflow,
    output logic [7:0] reject_count,
    output logic [1:0] state
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 27'd1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 28'd1);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHOW = 2'd2, LINGER = 2'd3} state_t;

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             rx_busy_q;
    logic [5:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [5:0]       cand;
    logic             done, good, empty, pop, push;

    assign cand      = {rx_data[2], rx_data[3], rx_data[4], rx_data[5], rx_data[6], rx_data[7]};
    assign done      = rx_busy_q & ~rx_busy;
    assign good      = done & (rx_data[1:0] == 2'b00) & (cand <= MAX_ID);
    assign empty     = count == '0;
    assign fifo_full = count == (AW+1)'(DEPTH);
    assign pop       = (st == LOAD) & ~empty;
    assign push      = good & (~fifo_full | pop);
    assign state     = st;

    // FIFO storage; a full FIFO still accepts a byte when the head leaves on the same edge
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cand;
    end

    // byte detection, queue bookkeeping, overflow flag and reject counter
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            rx_busy_q    <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            reject_count <= 8'd0;
        end else begin
            rx_busy_q <= rx_busy;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (good & fifo_full & ~pop) overflow <= 1'b1;
            if (done & ~good & (reject_count != 8'hFF)) reject_count <= reject_count + 8'd1;
        end
    end

    // display sequencer: load head, hold it, linger on the last ID, then blank
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            st       <= IDLE;
            cnt      <= '0;
            id_out   <= BLANK_ID;
            id_valid <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    id_out   <= BLANK_ID;
                    id_valid <= 1'b0;
                    if (!empty) st <= LOAD;
                end
                LOAD: begin
                    id_out   <= mem[rd_ptr];
                    id_valid <= 1'b1;
                    cnt      <= '0;
                    st       <= SHOW;
                end
                SHOW: begin
                    if (cnt == HOLD_LAST) begin
                        if (!empty) st <= LOAD;
                        else begin
                            cnt <= '0;
                            st  <= LINGER;
                        end
                    end else cnt <= cnt + CNT_W'(1);
                end
                LINGER: begin
                    if (!empty) st <= LOAD;
                    else if (cnt == IDLE_LAST) begin
                        st       <= IDLE;
                        id_out   <= BLANK_ID;
                        id_valid <= 1'b0;
                    end else cnt <= cnt + CNT_W'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_voice_display_scheduler.sv
// tb_voice_display_scheduler: directed scenario tests for the voice display scheduler
module tb_voice_display_scheduler;
    logic       clk = 1'b0;
    logic       nRESET;
    logic [7:0] rx_data;
    logic       rx_busy;
    logic [5:0] id_out;
    logic       id_valid, fifo_full, overflow;
    logic [7:0] reject_count;
    logic [1:0] state;
    int n_cmp = 0;
    int n_bad = 0;

    voice_display_scheduler #(
        .DEPTH(4), .HOLD_CYCLES(27'd8), .IDLE_CYCLES(28'd16), .CNT_W(5)
    ) dut (
        .clk(clk), .nRESET(nRESET), .rx_data(rx_data), .rx_busy(rx_busy),
        .id_out(id_out), .id_valid(id_valid), .fifo_full(fifo_full),
        .overflow(overflow), .reject_count(reject_count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // raise busy for one edge, drop it; the second edge is the push edge
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_busy = 1'b1;
        step(1);
        rx_busy = 1'b0;
        step(1);
    endtask

    task automatic test_reset;
        nRESET = 1'b0; rx_busy = 1'b1; rx_data = 8'hFF;
        step(3);
        n_cmp++; if (id_out !== 6'd63) begin n_bad++; $display("FAIL rst_id got %0d want 63", id_out); end
        n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", id_valid); end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL rst_state got %0d want 0", state); end
        n_cmp++; if (reject_count !== 8'd0) begin n_bad++; $display("FAIL rst_rej got %0d want 0", reject_count); end
        n_cmp++; if ({fifo_full, overflow} !== 2'b00) begin n_bad++; $display("FAIL rst_flags got %b want 00", {fifo_full, overflow}); end
        nRESET = 1'b1;
        step(2);
        n_cmp++; if (reject_count !== 8'd0) begin n_bad++; $display("FAIL rst_release_rej got %0d want 0", reject_count); end
        rx_busy = 1'b0;
        step(1);
        n_cmp++; if (reject_count !== 8'd1) begin n_bad++; $display("FAIL rst_fall_rej got %0d want 1", reject_count); end
        step(2);
        n_cmp++; if (reject_count !== 8'd1) begin n_bad++; $display("FAIL rst_once_rej got %0d want 1", reject_count); end
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL rst_idle_state got %0d want 0", state); end
    endtask

    task automatic test_single;
        send(8'h50);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL single_e0_state got %0d want 0", state); end
        step(1);
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL single_load got %0d want 1", state); end
        n_cmp++; if (id_out !== 6'd63) begin n_bad++; $display("FAIL single_e1_id got %0d want 63", id_out); end
        step(1);
        n_cmp++; if (id_out !== 6'd10) begin n_bad++; $display("FAIL single_id got %0d want 10", id_out); end
        n_cmp++; if ({id_valid, state} !== 3'b110) begin n_bad++; $display("FAIL single_show got %b want 110", {id_valid, state}); end
        step(7);
        n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL single_hold got %0d want 2", state); end
        step(1);
        n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL single_linger got %0d want 3", state); end
        step(15);
        n_cmp++; if ({id_valid, state, id_out} !== {1'b1, 2'd3, 6'd10}) begin n_bad++; $display("FAIL single_linger_end got %b want %b", {id_valid, state, id_out}, {1'b1, 2'd3, 6'd10}); end
        step(1);
        n_cmp++; if ({id_valid, state, id_out} !== {1'b0, 2'd0, 6'd63}) begin n_bad++; $display("FAIL single_blank got %b want %b", {id_valid, state, id_out}, {1'b0, 2'd0, 6'd63}); end
    endtask

    task automatic test_back_to_back;
        send(8'h50);
        send(8'h90);
        n_cmp++; if ({state, id_out} !== {2'd2, 6'd10}) begin n_bad++; $display("FAIL b2b_first got %b want %b", {state, id_out}, {2'd2, 6'd10}); end
        step(8);
        n_cmp++; if ({state, id_out} !== {2'd1, 6'd10}) begin n_bad++; $display("FAIL b2b_reload got %b want %b", {state, id_out}, {2'd1, 6'd10}); end
        step(1);
        n_cmp++; if ({state, id_out} !== {2'd2, 6'd9}) begin n_bad++; $display("FAIL b2b_second got %b want %b", {state, id_out}, {2'd2, 6'd9}); end
        step(8);
        n_cmp++; if ({state, id_out} !== {2'd3, 6'd9}) begin n_bad++; $display("FAIL b2b_linger got %b want %b", {state, id_out}, {2'd3, 6'd9}); end
        step(16);
        n_cmp++; if ({id_valid, state, id_out} !== {1'b0, 2'd0, 6'd63}) begin n_bad++; $display("FAIL b2b_blank got %b want %b", {id_valid, state, id_out}, {1'b0, 2'd0, 6'd63}); end
    endtask

    task automatic test_invalid;
        send(8'h51);
        send(8'hFC);
        step(2);
        n_cmp++; if (reject_count !== 8'd3) begin n_bad++; $display("FAIL inv_rej got %0d want 3", reject_count); end
        n_cmp++; if ({state, fifo_full, id_valid} !== 4'b0000) begin n_bad++; $display("FAIL inv_idle got %b want 0000", {state, fifo_full, id_valid}); end
    endtask

    task automatic test_overflow;
        send(8'h80);
        send(8'h40);
        n_cmp++; if ({state, id_out} !== {2'd2, 6'd1}) begin n_bad++; $display("FAIL ovf_show1 got %b want %b", {state, id_out}, {2'd2, 6'd1}); end
        send(8'hC0);
        send(8'h20);
        n_cmp++; if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL ovf_not_full got %b want 0", fifo_full); end
        send(8'hA0);
        n_cmp++; if ({fifo_full, overflow} !== 2'b10) begin n_bad++; $display("FAIL ovf_full got %b want 10", {fifo_full, overflow}); end
        send(8'h60);
        n_cmp++; if ({state, fifo_full, overflow} !== 4'b0111) begin n_bad++; $display("FAIL ovf_drop got %b want 0111", {state, fifo_full, overflow}); end
        send(8'hE0);
        n_cmp++; if ({id_out, fifo_full, overflow} !== {6'd2, 2'b11}) begin n_bad++; $display("FAIL ovf_show2 got %b want %b", {id_out, fifo_full, overflow}, {6'd2, 2'b11}); end
        step(6);
        send(8'h10);
        n_cmp++; if ({state, id_out, fifo_full, overflow} !== {2'd2, 6'd3, 2'b11}) begin n_bad++; $display("FAIL ovf_poppush got %b want %b", {state, id_out, fifo_full, overflow}, {2'd2, 6'd3, 2'b11}); end
    endtask

    task automatic test_mid_reset;
        step(9);
        n_cmp++; if ({state, id_out} !== {2'd2, 6'd4}) begin n_bad++; $display("FAIL mrst_show4 got %b want %b", {state, id_out}, {2'd2, 6'd4}); end
        step(3);
        #2 nRESET = 1'b0;
        #1;
        n_cmp++; if ({id_out, id_valid, state} !== {6'd63, 1'b0, 2'd0}) begin n_bad++; $display("FAIL mrst_async got %b want %b", {id_out, id_valid, state}, {6'd63, 1'b0, 2'd0}); end
        n_cmp++; if ({fifo_full, overflow, reject_count} !== 10'd0) begin n_bad++; $display("FAIL mrst_flags got %b want 0", {fifo_full, overflow, reject_count}); end
        step(2);
        nRESET = 1'b1;
        step(3);
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL mrst_empty got %0d want 0", state); end
        send(8'h90);
        step(2);
        n_cmp++; if ({id_valid, state, id_out} !== {1'b1, 2'd2, 6'd9}) begin n_bad++; $display("FAIL mrst_new got %b want %b", {id_valid, state, id_out}, {1'b1, 2'd2, 6'd9}); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_invalid;
        test_overflow;
        test_mid_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
